// File: rtl/swivm_console_tx.sv
// rtl/swivm_console_tx.sv - buffered 8N1 UART transmitter for CPU console output
//
// Purpose: accepts console bytes over a valid/ready handshake into a small
// FIFO and serialises them LSB first as 8N1 on o_tx. The producer only
// stalls when the FIFO is full.
//
// Ports:
//   i_clk    system clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   i_valid  producer presents a byte this cycle
//   i_data   byte to transmit
//   o_ready  FIFO not full; a byte is taken on i_valid && o_ready
//   o_tx     serial line, idles high
//   o_idle   FIFO empty and transmitter idle

module swivm_console_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_AW      = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_tx,
  output logic       o_idle
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int BW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t           state, state_next;
  logic [7:0]       mem [DEPTH];
  logic [FIFO_AW:0] wr_ptr, rd_ptr;
  logic [7:0]       shift, shift_next;
  logic [2:0]       bit_idx, bit_idx_next;
  logic [BW-1:0]    baud, baud_next;
  logic             tx_q, tx_next;
  logic             empty, full, push, pop, baud_end;
  logic [7:0]       head;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                    (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  // Ready depends on stored state only, so a full FIFO refuses a push even
  // when a pop happens on the same edge.
  assign push     = i_valid && !full;
  assign head     = mem[rd_ptr[FIFO_AW-1:0]];
  assign baud_end = (baud == BAUD_LAST);

  assign o_ready = !full;
  assign o_idle  = empty && (state == S_IDLE);
  assign o_tx    = tx_q;

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr[FIFO_AW-1:0]] <= i_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= S_IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      shift   <= '0;
      bit_idx <= '0;
      baud    <= '0;
      tx_q    <= 1'b1;
    end else begin
      state   <= state_next;
      shift   <= shift_next;
      bit_idx <= bit_idx_next;
      baud    <= baud_next;
      tx_q    <= tx_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_comb begin
    state_next   = state;
    shift_next   = shift;
    bit_idx_next = bit_idx;
    baud_next    = baud;
    pop          = 1'b0;
    tx_next      = 1'b1;

    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          shift_next = head;
          baud_next  = '0;
          state_next = S_START;
        end
      end
      S_START: begin
        if (baud_end) begin
          baud_next    = '0;
          bit_idx_next = '0;
          state_next   = S_DATA;
        end else begin
          baud_next = baud + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_next    = '0;
          shift_next   = {1'b0, shift[7:1]};
          bit_idx_next = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_next = S_STOP;
        end else begin
          baud_next = baud + 1'b1;
        end
      end
      S_STOP: begin
        if (baud_end) begin
          baud_next = '0;
          // Chain straight into the next start bit so frames are contiguous.
          if (!empty) begin
            pop        = 1'b1;
            shift_next = head;
            state_next = S_START;
          end else begin
            state_next = S_IDLE;
          end
        end else begin
          baud_next = baud + 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase

    // The pin level is decided one cycle ahead and registered, keeping the
    // FIFO read path away from o_tx.
    case (state_next)
      S_START: tx_next = 1'b0;
      S_DATA:  tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_swivm_console_tx.sv
// tb/tb_swivm_console_tx.sv - self-checking bench for swivm_console_tx

module tb_swivm_console_tx;

  localparam int C     = 4;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;
  localparam int FRAME = 10 * C;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_valid;
  logic [7:0] i_data;
  logic       o_ready;
  logic       o_tx;
  logic       o_idle;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: queue of waiting bytes plus the frame in flight,
  // described by its byte and the number of cycles since it started.
  logic [7:0] q[$];
  logic [7:0] m_cur;
  bit         m_busy;
  int         m_pos;
  bit         m_acc;

  swivm_console_tx #(.CLKS_PER_BIT(C), .FIFO_AW(AW)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_valid),
    .i_data  (i_data),
    .o_ready (o_ready),
    .o_tx    (o_tx),
    .o_idle  (o_idle)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    q.delete();
    m_busy = 1'b0;
    m_pos  = 0;
    m_cur  = 8'h00;
    m_acc  = 1'b0;
  endtask

  // Line level of a frame: start 0, data LSB first, stop 1.
  function automatic logic exp_tx();
    int seg;
    if (!m_busy) return 1'b1;
    seg = m_pos / C;
    if (seg == 0) return 1'b0;
    if (seg == 9) return 1'b1;
    return m_cur[seg-1];
  endfunction

  function automatic logic exp_ready();
    return (q.size() < DEPTH);
  endfunction

  function automatic logic exp_idle();
    return !m_busy && (q.size() == 0);
  endfunction

  // One rising edge: advance the model using pre-edge inputs, then return
  // at the falling edge where outputs are sampled and inputs are changed.
  task automatic step();
    @(posedge i_clk);
    if (!i_rst_n) begin
      model_reset();
    end else begin
      m_acc = i_valid && (q.size() < DEPTH);
      if (!m_busy || m_pos == FRAME - 1) begin
        if (q.size() > 0) begin
          m_cur  = q.pop_front();
          m_busy = 1'b1;
          m_pos  = 0;
        end else begin
          m_busy = 1'b0;
        end
      end else begin
        m_pos++;
      end
      if (m_acc) q.push_back(i_data);
    end
    @(negedge i_clk);
    cyc++;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_data  = 8'h00;
    model_reset();
    repeat (3) begin
      step();
      checks += 3;
      if (o_tx !== 1'b1)    begin errors++; $display("FAIL reset_tx got=%b exp=1", o_tx); end
      if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
      if (o_idle !== 1'b1)  begin errors++; $display("FAIL reset_idle got=%b exp=1", o_idle); end
    end
    i_rst_n = 1'b1;
    repeat (5) begin
      step();
      checks += 3;
      if (o_tx !== 1'b1)    begin errors++; $display("FAIL post_reset_tx got=%b exp=1", o_tx); end
      if (o_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got=%b exp=1", o_ready); end
      if (o_idle !== 1'b1)  begin errors++; $display("FAIL post_reset_idle got=%b exp=1", o_idle); end
    end
  endtask

  task automatic test_single_byte();
    logic pat [10];
    pat = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    i_valid = 1'b1;
    i_data  = 8'h41;
    step();
    i_valid = 1'b0;
    checks += 2;
    if (o_idle !== 1'b0) begin errors++; $display("FAIL single_idle_fall got=%b exp=0", o_idle); end
    if (o_tx !== 1'b1)   begin errors++; $display("FAIL single_tx_before_start got=%b exp=1", o_tx); end
    for (int j = 0; j < FRAME; j++) begin
      step();
      checks += 2;
      if (o_tx !== pat[j/C]) begin
        errors++; $display("FAIL single_tx cycle=%0d got=%b exp=%b", j, o_tx, pat[j/C]);
      end
      if (o_idle !== 1'b0) begin errors++; $display("FAIL single_idle_busy cycle=%0d got=%b exp=0", j, o_idle); end
    end
    step();
    checks += 2;
    if (o_idle !== 1'b1) begin errors++; $display("FAIL single_idle_end got=%b exp=1", o_idle); end
    if (o_tx !== 1'b1)   begin errors++; $display("FAIL single_tx_end got=%b exp=1", o_tx); end
  endtask

  task automatic test_back_to_back();
    i_valid = 1'b1;
    i_data  = 8'h48;
    step();
    i_data  = 8'h69;
    step();
    i_valid = 1'b0;
    for (int j = 0; j < 2 * FRAME + 5; j++) begin
      checks += 3;
      if (o_tx !== exp_tx())       begin errors++; $display("FAIL b2b_tx cyc=%0d got=%b exp=%b", cyc, o_tx, exp_tx()); end
      if (o_idle !== exp_idle())   begin errors++; $display("FAIL b2b_idle cyc=%0d got=%b exp=%b", cyc, o_idle, exp_idle()); end
      if (o_ready !== exp_ready()) begin errors++; $display("FAIL b2b_ready cyc=%0d got=%b exp=%b", cyc, o_ready, exp_ready()); end
      step();
    end
    checks++;
    if (o_idle !== 1'b1) begin errors++; $display("FAIL b2b_idle_end got=%b exp=1", o_idle); end
  endtask

  task automatic test_full_fifo();
    int b;
    int e;
    int acc6;
    b    = 1;
    e    = 0;
    acc6 = -1;
    i_valid = 1'b1;
    while (b <= 6 && e < 200) begin
      i_data = 8'(b);
      step();
      if (m_acc) begin
        if (b == 6) acc6 = e;
        b++;
      end
      e++;
      checks += 2;
      if (o_ready !== exp_ready()) begin errors++; $display("FAIL full_ready edge=%0d got=%b exp=%b", e - 1, o_ready, exp_ready()); end
      if (o_tx !== exp_tx())       begin errors++; $display("FAIL full_tx edge=%0d got=%b exp=%b", e - 1, o_tx, exp_tx()); end
    end
    i_valid = 1'b0;
    checks++;
    if (acc6 != 2 + FRAME) begin errors++; $display("FAIL full_accept6_edge got=%0d exp=%0d", acc6, 2 + FRAME); end
    for (int j = 0; j < 6 * FRAME + 5; j++) begin
      step();
      checks += 3;
      if (o_tx !== exp_tx())       begin errors++; $display("FAIL full_drain_tx cyc=%0d got=%b exp=%b", cyc, o_tx, exp_tx()); end
      if (o_idle !== exp_idle())   begin errors++; $display("FAIL full_drain_idle cyc=%0d got=%b exp=%b", cyc, o_idle, exp_idle()); end
      if (o_ready !== exp_ready()) begin errors++; $display("FAIL full_drain_ready cyc=%0d got=%b exp=%b", cyc, o_ready, exp_ready()); end
    end
  endtask

  task automatic test_simultaneous();
    // A at edge 0 starts at edge 1 and ends at edge 1+FRAME; B and C wait.
    i_valid = 1'b1;
    repeat (3) begin
      i_data = 8'($urandom);
      step();
    end
    i_valid = 1'b0;
    repeat (FRAME - 2) step();
    checks++;
    if (o_tx !== 1'b1) begin errors++; $display("FAIL simul_stop_level got=%b exp=1", o_tx); end
    i_valid = 1'b1;
    i_data  = 8'($urandom);
    step();
    i_valid = 1'b0;
    checks += 3;
    if (o_ready !== 1'b1) begin errors++; $display("FAIL simul_ready got=%b exp=1", o_ready); end
    if (o_tx !== 1'b0)    begin errors++; $display("FAIL simul_next_start got=%b exp=0", o_tx); end
    if (!m_acc)           begin errors++; $display("FAIL simul_push_taken got=0 exp=1"); end
    for (int j = 0; j < 3 * FRAME + 5; j++) begin
      step();
      checks += 2;
      if (o_tx !== exp_tx())     begin errors++; $display("FAIL simul_tx cyc=%0d got=%b exp=%b", cyc, o_tx, exp_tx()); end
      if (o_idle !== exp_idle()) begin errors++; $display("FAIL simul_idle cyc=%0d got=%b exp=%b", cyc, o_idle, exp_idle()); end
    end
  endtask

  task automatic test_reset_mid_frame();
    int n;
    i_valid = 1'b1;
    i_data  = 8'hF0;
    step();
    repeat (4) begin
      i_data = 8'($urandom);
      step();
    end
    i_valid = 1'b0;
    n = 0;
    while (!(m_busy && (m_pos / C) == 4) && n < 100) begin
      step();
      n++;
    end
    checks += 3;
    if (n >= 100)         begin errors++; $display("FAIL midrst_reach_bit3 got=timeout exp=bit3"); end
    if (o_tx !== 1'b0)    begin errors++; $display("FAIL midrst_bit3_level got=%b exp=0", o_tx); end
    if (o_ready !== 1'b0) begin errors++; $display("FAIL midrst_full got=%b exp=0", o_ready); end
    #1;
    i_rst_n = 1'b0;
    #1;
    checks += 3;
    if (o_tx !== 1'b1)    begin errors++; $display("FAIL midrst_async_tx got=%b exp=1", o_tx); end
    if (o_ready !== 1'b1) begin errors++; $display("FAIL midrst_async_ready got=%b exp=1", o_ready); end
    if (o_idle !== 1'b1)  begin errors++; $display("FAIL midrst_async_idle got=%b exp=1", o_idle); end
    model_reset();
    step();
    step();
    i_rst_n = 1'b1;
    for (int j = 0; j < FRAME + 10; j++) begin
      step();
      checks += 2;
      if (o_tx !== 1'b1)   begin errors++; $display("FAIL midrst_after_tx cyc=%0d got=%b exp=1", cyc, o_tx); end
      if (o_idle !== 1'b1) begin errors++; $display("FAIL midrst_after_idle cyc=%0d got=%b exp=1", cyc, o_idle); end
    end
  endtask

  task automatic test_random();
    bit last_acc;
    int dens;
    int k;
    last_acc = 1'b0;
    dens     = 10;
    i_valid  = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      if (n % 200 == 0) dens = ($urandom_range(0, 2) == 0) ? 80 : $urandom_range(1, 8);
      // A held byte stays put until accepted.
      if (!i_valid || last_acc) begin
        i_valid = ($urandom_range(0, 99) < dens);
        i_data  = 8'($urandom);
      end
      step();
      last_acc = m_acc;
      checks += 3;
      if (o_tx !== exp_tx())       begin errors++; $display("FAIL rand_tx cyc=%0d got=%b exp=%b", cyc, o_tx, exp_tx()); end
      if (o_idle !== exp_idle())   begin errors++; $display("FAIL rand_idle cyc=%0d got=%b exp=%b", cyc, o_idle, exp_idle()); end
      if (o_ready !== exp_ready()) begin errors++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, o_ready, exp_ready()); end
    end
    i_valid = 1'b0;
    k = 0;
    while (!exp_idle() && k < (DEPTH + 2) * FRAME) begin
      step();
      k++;
      checks += 2;
      if (o_tx !== exp_tx())     begin errors++; $display("FAIL rand_drain_tx cyc=%0d got=%b exp=%b", cyc, o_tx, exp_tx()); end
      if (o_idle !== exp_idle()) begin errors++; $display("FAIL rand_drain_idle cyc=%0d got=%b exp=%b", cyc, o_idle, exp_idle()); end
    end
    checks++;
    if (o_idle !== 1'b1) begin errors++; $display("FAIL rand_final_idle got=%b exp=1", o_idle); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_full_fifo();
    test_simultaneous();
    test_reset_mid_frame();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
